// File: rtl/parking_exit_gate.sv
// Exit gate controller: validates exit tokens, drives the barrier LEDs and status digits,
// and keeps the lot occupancy count shared with the entrance side.
module parking_exit_gate #(
    parameter int CAPACITY    = 9,
    parameter int PAY_TIMEOUT = 15,
    parameter int OPEN_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_entered,
    input  logic       sensor_exit_approach,
    input  logic       sensor_exit_clear,
    input  logic       token_valid,
    input  logic [1:0] token_code,
    output logic       GREEN_LED,
    output logic       RED_LED,
    output logic       FULL,
    output logic [3:0] occupancy,
    output logic [6:0] HEX_1,
    output logic [6:0] HEX_2
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TOKEN,
        S_OPEN,
        S_REJECT
    } state_t;

    localparam logic [3:0] CAP_L     = 4'(CAPACITY);
    localparam logic [3:0] PAY_LAST  = 4'(PAY_TIMEOUT - 1);
    localparam logic [3:0] OPEN_LAST = 4'(OPEN_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_pay_timer;
    logic [3:0] w_pay_timer_nxt;
    logic [3:0] r_open_timer;
    logic [3:0] w_open_timer_nxt;
    logic [3:0] r_occ;
    logic [3:0] w_occ_nxt;
    logic       r_green;
    logic       r_red;
    logic       r_full;
    logic [6:0] r_hex1;
    logic [6:0] r_hex2;
    logic       w_green_nxt;
    logic       w_red_nxt;
    logic [6:0] w_hex1_nxt;
    logic       w_token_ok;
    logic       w_inc;
    logic       w_dec;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_token_ok  = token_valid && (token_code == 2'b11);
        case (r_state)
            S_IDLE: begin
                if (sensor_exit_approach && (r_occ != 4'd0))
                    w_state_nxt = S_WAIT_TOKEN;
            end
            S_WAIT_TOKEN: begin
                // A token in the timeout cycle still wins over the timeout.
                if (token_valid)
                    w_state_nxt = w_token_ok ? S_OPEN : S_REJECT;
                else if (r_pay_timer == PAY_LAST)
                    w_state_nxt = S_REJECT;
                else if (!sensor_exit_approach)
                    w_state_nxt = S_IDLE;
            end
            S_REJECT: begin
                if (w_token_ok)
                    w_state_nxt = S_OPEN;
                else if (!sensor_exit_approach)
                    w_state_nxt = S_IDLE;
            end
            S_OPEN: begin
                if (sensor_exit_clear || (r_open_timer == OPEN_LAST))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_pay_timer_nxt  = 4'd0;
        w_open_timer_nxt = 4'd0;
        if ((r_state == S_WAIT_TOKEN) && (w_state_nxt == S_WAIT_TOKEN))
            w_pay_timer_nxt = r_pay_timer + 4'd1;
        if ((r_state == S_OPEN) && (w_state_nxt == S_OPEN))
            w_open_timer_nxt = r_open_timer + 4'd1;

        // Simultaneous admission and exit cancel, even when the lot is full.
        w_inc     = car_entered;
        w_dec     = (r_state == S_OPEN) && sensor_exit_clear && (r_occ != 4'd0);
        w_occ_nxt = r_occ;
        if (w_inc && w_dec)
            w_occ_nxt = r_occ;
        else if (w_inc && (r_occ != CAP_L))
            w_occ_nxt = r_occ + 4'd1;
        else if (w_dec)
            w_occ_nxt = r_occ - 4'd1;

        w_green_nxt = 1'b0;
        w_red_nxt   = 1'b0;
        w_hex1_nxt  = SEG_BLANK;
        case (w_state_nxt)
            S_WAIT_TOKEN: begin
                w_red_nxt  = 1'b1;
                w_hex1_nxt = 7'b0001100;
            end
            S_OPEN: begin
                w_green_nxt = 1'b1;
                w_hex1_nxt  = 7'b1000000;
            end
            S_REJECT: begin
                w_red_nxt  = (r_state == S_REJECT) ? ~r_red : 1'b1;
                w_hex1_nxt = 7'b0000110;
            end
            default: begin
                w_red_nxt  = 1'b0;
                w_hex1_nxt = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pay_timer  <= 4'd0;
            r_open_timer <= 4'd0;
            r_occ        <= 4'd0;
            r_green      <= 1'b0;
            r_red        <= 1'b0;
            r_full       <= 1'b0;
            r_hex1       <= SEG_BLANK;
            r_hex2       <= SEG_BLANK;
        end else begin
            r_state      <= w_state_nxt;
            r_pay_timer  <= w_pay_timer_nxt;
            r_open_timer <= w_open_timer_nxt;
            r_occ        <= w_occ_nxt;
            r_green      <= w_green_nxt;
            r_red        <= w_red_nxt;
            r_full       <= (w_occ_nxt == CAP_L);
            r_hex1       <= w_hex1_nxt;
            r_hex2       <= seg_digit(CAP_L - w_occ_nxt);
        end
    end

    assign GREEN_LED = r_green;
    assign RED_LED   = r_red;
    assign FULL      = r_full;
    assign occupancy = r_occ;
    assign HEX_1     = r_hex1;
    assign HEX_2     = r_hex2;

endmodule

// File: tb/tb_parking_exit_gate.sv
// Bench for parking_exit_gate: a phase/counter reference model queues the expected outputs
// for every clock edge and an independent monitor compares them against the gate.
module tb_parking_exit_gate;

    localparam int CAP = 9;
    localparam int PT  = 15;
    localparam int OC  = 8;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_OPEN = 2;
    localparam int P_REJ  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_entered = 1'b0;
    logic       sensor_exit_approach = 1'b0;
    logic       sensor_exit_clear = 1'b0;
    logic       token_valid = 1'b0;
    logic [1:0] token_code = 2'b00;
    logic       GREEN_LED;
    logic       RED_LED;
    logic       FULL;
    logic [3:0] occupancy;
    logic [6:0] HEX_1;
    logic [6:0] HEX_2;

    parking_exit_gate #(
        .CAPACITY   (CAP),
        .PAY_TIMEOUT(PT),
        .OPEN_CYCLES(OC)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .car_entered         (car_entered),
        .sensor_exit_approach(sensor_exit_approach),
        .sensor_exit_clear   (sensor_exit_clear),
        .token_valid         (token_valid),
        .token_code          (token_code),
        .GREEN_LED           (GREEN_LED),
        .RED_LED             (RED_LED),
        .FULL                (FULL),
        .occupancy           (occupancy),
        .HEX_1               (HEX_1),
        .HEX_2               (HEX_2)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic       green;
        logic       red;
        logic       full;
        logic [3:0] occ;
        logic [6:0] hex1;
        logic [6:0] hex2;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp;
    obs_t mon_act;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    int m_phase = P_IDLE;
    int m_cnt   = 0;
    int m_occ   = 0;

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] letter_seg(input int ph);
        case (ph)
            P_WAIT: return 7'b0001100;
            P_OPEN: return 7'b1000000;
            P_REJ:  return 7'b0000110;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model: advance one clock edge from the inputs present at that edge.
    task automatic model_edge();
        int   np;
        bit   tok_ok;
        bit   leaving;
        obs_t e;
        if (reset) begin
            m_phase = P_IDLE;
            m_cnt   = 0;
            m_occ   = 0;
            e = '{green: 1'b0, red: 1'b0, full: 1'b0, occ: 4'd0,
                  hex1: 7'b1111111, hex2: 7'b1111111};
        end else begin
            tok_ok = token_valid && (token_code == 2'b11);
            np = m_phase;
            case (m_phase)
                P_IDLE: if (sensor_exit_approach && m_occ > 0) np = P_WAIT;
                P_WAIT: begin
                    if (token_valid) np = tok_ok ? P_OPEN : P_REJ;
                    else if (m_cnt == PT - 1) np = P_REJ;
                    else if (!sensor_exit_approach) np = P_IDLE;
                end
                P_REJ: begin
                    if (tok_ok) np = P_OPEN;
                    else if (!sensor_exit_approach) np = P_IDLE;
                end
                default: if (sensor_exit_clear || m_cnt == OC - 1) np = P_IDLE;
            endcase
            leaving = (m_phase == P_OPEN) && sensor_exit_clear && (m_occ > 0);
            if (car_entered && leaving) m_occ = m_occ;
            else if (car_entered) m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
            else if (leaving) m_occ = m_occ - 1;
            m_cnt   = (np == m_phase) ? m_cnt + 1 : 0;
            m_phase = np;
            e.green = (m_phase == P_OPEN);
            e.red   = (m_phase == P_WAIT) || (m_phase == P_REJ && (m_cnt % 2) == 0);
            e.full  = (m_occ == CAP);
            e.occ   = 4'(m_occ);
            e.hex1  = letter_seg(m_phase);
            e.hex2  = digit_seg(CAP - m_occ);
        end
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(posedge clk);
        #1;
        cycle++;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL edge_outputs cycle %0d: no expected entry queued", cycle);
        end else begin
            mon_exp = exp_q.pop_front();
            mon_act = '{green: GREEN_LED, red: RED_LED, full: FULL, occ: occupancy,
                        hex1: HEX_1, hex2: HEX_2};
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL edge_outputs cycle %0d: got g=%b r=%b f=%b occ=%0d h1=%b h2=%b, want g=%b r=%b f=%b occ=%0d h1=%b h2=%b",
                         cycle, mon_act.green, mon_act.red, mon_act.full, mon_act.occ,
                         mon_act.hex1, mon_act.hex2, mon_exp.green, mon_exp.red,
                         mon_exp.full, mon_exp.occ, mon_exp.hex1, mon_exp.hex2);
            end
        end
    end

    task automatic spot(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic step(input logic ce, input logic app, input logic tv,
                        input logic [1:0] tc, input logic clr);
        car_entered          = ce;
        sensor_exit_approach = app;
        token_valid          = tv;
        token_code           = tc;
        sensor_exit_clear    = clr;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        spot({tag, "_green"}, 32'(GREEN_LED), 32'd0);
        spot({tag, "_red"},   32'(RED_LED),   32'd0);
        spot({tag, "_full"},  32'(FULL),      32'd0);
        spot({tag, "_occ"},   32'(occupancy), 32'd0);
        spot({tag, "_hex1"},  32'(HEX_1),     32'h7F);
        spot({tag, "_hex2"},  32'(HEX_2),     32'h7F);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Three admissions.
        repeat (3) step(1, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0);
        spot("occ_after_3", 32'(occupancy), 32'd3);
        spot("hex2_after_3", 32'(HEX_2), 32'(digit_seg(CAP - 3)));
        spot("full_after_3", 32'(FULL), 32'd0);

        // Paid exit, token on the second waiting cycle.
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 1, 2'b11, 0);
        spot("green_on_token", 32'(GREEN_LED), 32'd1);
        step(0, 0, 0, 2'b00, 1);
        spot("occ_after_exit", 32'(occupancy), 32'd2);
        spot("hex2_after_exit", 32'(HEX_2), 32'(digit_seg(CAP - 2)));

        // Payment timeout, then a late correct token.
        step(0, 1, 0, 2'b00, 0);
        repeat (PT - 1) step(0, 1, 0, 2'b00, 0);
        spot("hex1_before_timeout", 32'(HEX_1), 32'h0C);
        step(0, 1, 0, 2'b00, 0);
        spot("hex1_at_timeout", 32'(HEX_1), 32'h06);
        spot("red_reject_1", 32'(RED_LED), 32'd1);
        step(0, 1, 0, 2'b00, 0);
        spot("red_reject_2", 32'(RED_LED), 32'd0);
        step(0, 1, 0, 2'b00, 0);
        spot("red_reject_3", 32'(RED_LED), 32'd1);
        step(0, 1, 1, 2'b11, 0);
        spot("green_after_late_token", 32'(GREEN_LED), 32'd1);
        step(0, 0, 0, 2'b00, 0);
        repeat (OC) step(0, 0, 0, 2'b00, 0);

        // Wrong token, then the car leaves the approach.
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 1, 2'b01, 0);
        spot("hex1_bad_token", 32'(HEX_1), 32'h06);
        step(0, 0, 0, 2'b00, 0);
        spot("leds_after_drop", 32'({GREEN_LED, RED_LED}), 32'd0);

        // Fill the lot past capacity, then an exit coinciding with an admission.
        repeat (10) step(1, 0, 0, 2'b00, 0);
        spot("occ_saturated", 32'(occupancy), 32'(CAP));
        spot("full_saturated", 32'(FULL), 32'd1);
        spot("hex2_saturated", 32'(HEX_2), 32'h40);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 1, 2'b11, 0);
        step(1, 0, 0, 2'b00, 1);
        spot("occ_inc_and_dec", 32'(occupancy), 32'(CAP));

        // Asynchronous reset while the gate is open.
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 1, 2'b11, 0);
        spot("green_before_reset", 32'(GREEN_LED), 32'd1);
        car_entered = 1'b0; sensor_exit_approach = 1'b0; token_valid = 1'b0;
        sensor_exit_clear = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(0, 1, 0, 2'b00, 0);
        spot("approach_ignored_hex1", 32'(HEX_1), 32'h7F);
        spot("approach_ignored_leds", 32'({GREEN_LED, RED_LED}), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            logic app;
            app = sensor_exit_approach;
            if ($urandom_range(0, 9) == 0) app = ~app;
            step(($urandom_range(0, 3) == 0), app, ($urandom_range(0, 5) == 0),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end
        repeat (2) step(0, 0, 0, 2'b00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
